usb_tx_timer: RTL and testbench
===============================

// Module: usb_tx_timer
// PURPOSE
//  Bit-timing controller for the USB transmit path; the transmit-side counterpart of rx timing.
//  Divides clk into bit periods and strobes the tx shift register.
//  Fetches bytes from the tx byte buffer (byte_valid/byte_load handshake).
//  Signals end-of-packet to the EOP/NRZI driver; optionally inserts stuff bits.
// PARAMETERS
//  CLKS_PER_BIT   8  clk cycles per bit period (>=2)
//  BITS_PER_BYTE  8  bits shifted per loaded byte (>=2)
//  STUFF_RUN      6  consecutive ones that force a stuff bit (TX_BIT_STUFF_EN only)
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  tx_start      in   1  pulse: begin packet; ignored while tx_active=1
//  byte_valid    in   1  tx buffer holds a byte ready to load
//  last_byte     in   1  qualifies byte_valid: offered byte is the packet's final byte
//  tx_bit        in   1  serial bit currently driven (shift-register LSB); used for stuff tracking
//  byte_load     out  1  pulse: load shift register from buffer and pop buffer
//  shift_enable  out  1  pulse: shift tx shift register one bit
//  bit_strobe    out  1  pulse: first clk of every bit period, including stuff periods
//  stuff_insert  out  1  high for every clk of a stuffed bit period (tied 0 without macro)
//  eop_start     out  1  pulse: final bit period of packet completes
//  tx_error      out  1  pulse: buffer underflow at a byte boundary
//  tx_active     out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset: rst sampled high -> next edge state=IDLE, all counters 0, every output 0.
//  Reset applies in any state; a packet in flight is abandoned, with no eop_start and no tx_error.
//  Counters:
//   - clk_cnt: $clog2(CLKS_PER_BIT) bits; wraps CLKS_PER_BIT-1 -> 0.
//   - bit_cnt: $clog2(BITS_PER_BYTE) bits.
//   - ones_cnt: $clog2(STUFF_RUN+1) bits.
//  Let "bit_end" = clk_cnt==CLKS_PER_BIT-1 in SEND or STUFF.
//  States: IDLE, LOAD, SEND, STUFF.
//  IDLE:
//   - tx_start=1 -> LOAD.
//  LOAD (first byte only):
//   - Waits indefinitely for byte_valid; no underflow is possible here.
//   - When byte_valid=1, byte_load=1 in that same cycle (Mealy) and last_byte is latched.
//   - clk_cnt, bit_cnt and ones_cnt are cleared; next state SEND.
//  SEND:
//   - bit_strobe=1 when clk_cnt==0.
//   - At bit_end with bit_cnt<BITS_PER_BYTE-1: shift_enable=1, bit_cnt++.
//   - At bit_end with bit_cnt==BITS_PER_BYTE-1 (byte boundary): no shift_enable; bit_cnt -> 0.
//     - If the latched last flag is 0 and byte_valid=1: byte_load=1 in the same cycle; re-latch last_byte.
//     - If the latched last flag is 0 and byte_valid=0: tx_error=1 in the same cycle; next state IDLE.
//     - If the latched last flag is 1: eop_start=1 in the same cycle (unless a stuff bit is pending); next state IDLE.
//  Timing: tx_start at cycle 0 -> byte_load at cycle 1 (byte_valid high) -> first bit_strobe at cycle 2.
//   - N-byte packet without stuffing: eop_start at cycle 1+N*BITS_PER_BYTE*CLKS_PER_BIT.
//   - tx_active falls on the following cycle.
//  tx_start while tx_active=1: ignored. Simultaneous rst and tx_start: rst wins.
//  byte_load, shift_enable, eop_start and tx_error are single-cycle pulses, mutually exclusive per cycle.
// CONFIGURATION
//  Macro TX_BIT_STUFF_EN: bit stuffing.
//  Defined:
//   - At every SEND bit_end, ones_cnt <= tx_bit ? ones_cnt+1 : 0.
//   - If that update reaches STUFF_RUN, the normal bit_end actions (shift/load/error) still occur.
//     The next state is then STUFF instead of SEND/IDLE.
//   - STUFF lasts CLKS_PER_BIT clks: stuff_insert=1 throughout; bit_strobe at clk_cnt==0.
//     There is no shift_enable and bit_cnt does not change. ones_cnt is cleared on entry.
//   - Leaving STUFF: go to SEND, or to IDLE with eop_start=1 at its bit_end if the stuff followed the final bit.
//     An underflow at the stuffed byte boundary goes straight to IDLE with tx_error=1; no stuff period.
//  Undefined:
//   - STUFF state and ones_cnt are removed; stuff_insert is tied to 0; tx_bit is unused.
// TESTING
//  Use default parameters; cycle numbers are relative to the tx_start pulse at cycle 0.
//  1) rst=1 for 2 clks mid-IDLE -> all outputs 0; tx_active=0.
//  2) One byte, last_byte=1, byte_valid=1 -> byte_load@1; bit_strobe@2,10,..,58;
//     shift_enable@9,17,..,57 (7 pulses); eop_start@65; tx_active=0@66.
//  3) Two bytes, byte_valid held -> second byte_load@65 (no shift_enable@65);
//     eop_start@129; 16 bit_strobes in total.
//  4) Underflow: byte_valid=1@1 then 0, last_byte=0 -> tx_error@65, IDLE@66; no eop_start.
//  5) TX_BIT_STUFF_EN, byte 0xFF, tx_bit=1, last_byte=1 -> stuff_insert=1 for cycles 50-57;
//     bit_strobe@50; bits 6-7 at 58-73; eop_start@73.
//     Same stimulus without the macro -> eop_start@65; stuff_insert never asserted.
//  6) rst=1 @30 mid-packet -> all outputs 0 and tx_active=0 @31; a tx_start@20 has no effect.

Source files
------------

// File: rtl/usb_tx_timer.sv
// usb_tx_timer: bit-timing controller for the USB transmit path.
//   Divides clk into bit periods, strobes the tx shift register, fetches
//   bytes from the tx byte buffer and signals end-of-packet.
//   Optional feature macro: TX_BIT_STUFF_EN (bit stuffing after STUFF_RUN ones).
// Ports:
//   clk, rst      - clock (posedge) and synchronous active-high reset
//   tx_start      - pulse: begin packet (ignored while tx_active)
//   byte_valid    - buffer holds a byte; last_byte qualifies it as final
//   tx_bit        - serial bit currently driven (stuff tracking only)
//   byte_load     - pulse: load shift register / pop buffer
//   shift_enable  - pulse: shift one bit
//   bit_strobe    - pulse: first clk of every bit period
//   stuff_insert  - high throughout a stuffed bit period
//   eop_start     - pulse: final bit period completes
//   tx_error      - pulse: buffer underflow at a byte boundary
//   tx_active     - high whenever not IDLE
module usb_tx_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8,
  parameter int STUFF_RUN     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_start,
  input  logic byte_valid,
  input  logic last_byte,
  input  logic tx_bit,
  output logic byte_load,
  output logic shift_enable,
  output logic bit_strobe,
  output logic stuff_insert,
  output logic eop_start,
  output logic tx_error,
  output logic tx_active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BITS_PER_BYTE);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_BYTE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
`ifdef TX_BIT_STUFF_EN
    , STUFF
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            last_q, last_d;
  logic            bit_end;
  logic            boundary;

`ifdef TX_BIT_STUFF_EN
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_RUN);
  logic [OW-1:0]   ones_q, ones_d, ones_next;
  // Remembers that the stuff period follows the packet's final bit.
  logic            eop_pend_q, eop_pend_d;
`else
  logic            unused_tx_bit;
  assign unused_tx_bit = tx_bit;
`endif

  assign bit_end  = (clk_cnt_q == CLK_LAST);
  assign boundary = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    last_d       = last_q;
    byte_load    = 1'b0;
    shift_enable = 1'b0;
    bit_strobe   = 1'b0;
    stuff_insert = 1'b0;
    eop_start    = 1'b0;
    tx_error     = 1'b0;
    tx_active    = (state_q != IDLE);
`ifdef TX_BIT_STUFF_EN
    ones_d       = ones_q;
    ones_next    = '0;
    eop_pend_d   = eop_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_start) state_d = LOAD;
      end

      LOAD: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
`ifdef TX_BIT_STUFF_EN
        ones_d     = '0;
        eop_pend_d = 1'b0;
`endif
        if (byte_valid) begin
          byte_load = 1'b1;
          last_d    = last_byte;
          state_d   = SEND;
        end
      end

      SEND: begin
        bit_strobe = (clk_cnt_q == '0);
        clk_cnt_d  = bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          if (!boundary) begin
            shift_enable = 1'b1;
            bit_cnt_d    = bit_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (!last_q) begin
              if (byte_valid) begin
                byte_load = 1'b1;
                last_d    = last_byte;
              end else begin
                tx_error = 1'b1;
                state_d  = IDLE;
              end
            end else begin
              eop_start = 1'b1;
              state_d   = IDLE;
            end
          end
`ifdef TX_BIT_STUFF_EN
          ones_next = tx_bit ? ones_q + 1'b1 : '0;
          ones_d    = ones_next;
          // Shift/load still happen this cycle; only the successor state and
          // a final-bit eop are deferred until the stuff period ends.
          // An underflow bypasses stuffing entirely.
          if (ones_next == ONES_MAX && !tx_error) begin
            state_d    = STUFF;
            ones_d     = '0;
            eop_pend_d = boundary && last_q;
            eop_start  = 1'b0;
          end
`endif
        end
      end

`ifdef TX_BIT_STUFF_EN
      STUFF: begin
        stuff_insert = 1'b1;
        bit_strobe   = (clk_cnt_q == '0);
        clk_cnt_d    = bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          eop_pend_d = 1'b0;
          if (eop_pend_q) begin
            eop_start = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
`ifdef TX_BIT_STUFF_EN
      ones_q     <= '0;
      eop_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
`ifdef TX_BIT_STUFF_EN
      ones_q     <= ones_d;
      eop_pend_q <= eop_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_tx_timer.sv
module tb_usb_tx_timer;

  logic clk = 1'b0;
  logic rst, tx_start, byte_valid, last_byte, tx_bit;
  logic byte_load, shift_enable, bit_strobe, stuff_insert, eop_start, tx_error, tx_active;

  int checks = 0;
  int errors = 0;

  // Per-cycle record: {byte_load, shift_enable, bit_strobe, stuff_insert, eop_start, tx_error, tx_active}
  logic [6:0] outs [0:199];
  int n_bl, n_se, n_bs, n_si, n_eo, n_te, n_multi;

  usb_tx_timer #(.CLKS_PER_BIT(8), .BITS_PER_BYTE(8), .STUFF_RUN(6)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .byte_valid(byte_valid),
    .last_byte(last_byte), .tx_bit(tx_bit), .byte_load(byte_load),
    .shift_enable(shift_enable), .bit_strobe(bit_strobe),
    .stuff_insert(stuff_insert), .eop_start(eop_start), .tx_error(tx_error),
    .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 1: single byte, tx_bit=0; 2: two bytes; 3: underflow;
  // 5: single 0xFF byte with tx_bit=1; 6: reset mid-packet with stray tx_start@20
  task automatic run(input int mode, input int ncyc);
    n_bl = 0; n_se = 0; n_bs = 0; n_si = 0; n_eo = 0; n_te = 0; n_multi = 0;
    for (int c = 0; c < ncyc; c++) begin
      tx_start = (c == 0) || (mode == 6 && c == 20);
      rst      = (mode == 6 && c == 30);
      tx_bit   = (mode == 5);
      case (mode)
        2:       begin byte_valid = 1'b1;     last_byte = (c >= 2); end
        3:       begin byte_valid = (c == 1); last_byte = 1'b0;     end
        default: begin byte_valid = (c >= 1); last_byte = 1'b1;     end
      endcase
      @(negedge clk);
      outs[c] = {byte_load, shift_enable, bit_strobe, stuff_insert, eop_start, tx_error, tx_active};
      n_bl += int'(byte_load);
      n_se += int'(shift_enable);
      n_bs += int'(bit_strobe);
      n_si += int'(stuff_insert);
      n_eo += int'(eop_start);
      n_te += int'(tx_error);
      if ((int'(byte_load) + int'(shift_enable) + int'(eop_start) + int'(tx_error)) > 1) n_multi++;
      @(posedge clk); #1;
    end
    tx_start = 1'b0; rst = 1'b0; byte_valid = 1'b0; last_byte = 1'b0; tx_bit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; byte_valid = 1'b0; last_byte = 1'b0; tx_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", int'({byte_load, shift_enable, bit_strobe, stuff_insert, eop_start, tx_error, tx_active}), 0);

    // 1) reset held two clocks while idle
    @(posedge clk); #1 rst = 1'b1; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_reset_outputs", int'({byte_load, shift_enable, bit_strobe, stuff_insert, eop_start, tx_error, tx_active}), 0);
    @(posedge clk); #1;

    // 2) one byte, last
    run(1, 70);
    chk("t2_load_at_1", int'(outs[1][6]), 1);
    chk("t2_loads", n_bl, 1);
    chk("t2_strobe_at_2", int'(outs[2][4]), 1);
    chk("t2_strobe_at_58", int'(outs[58][4]), 1);
    chk("t2_strobes", n_bs, 8);
    chk("t2_shift_at_9", int'(outs[9][5]), 1);
    chk("t2_shift_at_57", int'(outs[57][5]), 1);
    chk("t2_no_shift_at_65", int'(outs[65][5]), 0);
    chk("t2_shifts", n_se, 7);
    chk("t2_eop_at_65", int'(outs[65][2]), 1);
    chk("t2_eops", n_eo, 1);
    chk("t2_active_at_65", int'(outs[65][0]), 1);
    chk("t2_active_at_66", int'(outs[66][0]), 0);
    chk("t2_no_error", n_te, 0);
    chk("t2_no_stuff", n_si, 0);

    // 3) two bytes
    run(2, 135);
    chk("t3_load_at_65", int'(outs[65][6]), 1);
    chk("t3_no_shift_at_65", int'(outs[65][5]), 0);
    chk("t3_no_eop_at_65", int'(outs[65][2]), 0);
    chk("t3_loads", n_bl, 2);
    chk("t3_strobe_at_66", int'(outs[66][4]), 1);
    chk("t3_strobes", n_bs, 16);
    chk("t3_shifts", n_se, 14);
    chk("t3_eop_at_129", int'(outs[129][2]), 1);
    chk("t3_eops", n_eo, 1);
    chk("t3_active_at_130", int'(outs[130][0]), 0);
    chk("t3_exclusive", n_multi, 0);

    // 4) underflow at first byte boundary
    run(3, 70);
    chk("t4_error_at_65", int'(outs[65][1]), 1);
    chk("t4_errors", n_te, 1);
    chk("t4_no_eop", n_eo, 0);
    chk("t4_loads", n_bl, 1);
    chk("t4_active_at_66", int'(outs[66][0]), 0);

    // 5) 0xFF with tx_bit=1
    run(5, 80);
    chk("t5_shifts", n_se, 7);
    chk("t5_exclusive", n_multi, 0);
`ifdef TX_BIT_STUFF_EN
    chk("t5_stuff_at_49", int'(outs[49][3]), 0);
    chk("t5_stuff_at_50", int'(outs[50][3]), 1);
    chk("t5_stuff_at_57", int'(outs[57][3]), 1);
    chk("t5_stuff_at_58", int'(outs[58][3]), 0);
    chk("t5_stuff_cycles", n_si, 8);
    chk("t5_strobe_at_50", int'(outs[50][4]), 1);
    chk("t5_strobe_at_58", int'(outs[58][4]), 1);
    chk("t5_strobe_at_66", int'(outs[66][4]), 1);
    chk("t5_strobes", n_bs, 9);
    chk("t5_no_eop_at_65", int'(outs[65][2]), 0);
    chk("t5_eop_at_73", int'(outs[73][2]), 1);
    chk("t5_eops", n_eo, 1);
    chk("t5_active_at_74", int'(outs[74][0]), 0);
`else
    chk("t5_eop_at_65", int'(outs[65][2]), 1);
    chk("t5_eops", n_eo, 1);
    chk("t5_stuff_cycles", n_si, 0);
    chk("t5_strobes", n_bs, 8);
    chk("t5_active_at_66", int'(outs[66][0]), 0);
`endif

    // 6) reset mid-packet, stray tx_start while active
    run(6, 70);
    chk("t6_loads", n_bl, 1);
    chk("t6_strobe_at_26", int'(outs[26][4]), 1);
    chk("t6_active_at_30", int'(outs[30][0]), 1);
    chk("t6_outputs_at_31", int'(outs[31]), 0);
    chk("t6_active_at_60", int'(outs[60][0]), 0);
    chk("t6_no_eop", n_eo, 0);
    chk("t6_no_error", n_te, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
